rv32_multicycle_control: RTL and testbench
==========================================

# rv32_multicycle_control

Multi-cycle control FSM for the RV32I core. Fetches one instruction per pass through an instruction-memory request/acknowledge handshake and decodes R-type and I-type ALU instructions. Drives register-file addresses, write enable, ALU op and operand select, and the PC advance. Sits between the pc / instruction_memory / register_file / alu datapath and replaces hard-wired single-cycle control.

## Interface
- No parameters. Widths are fixed: XLEN = 32, 5-bit register addresses.
- clk  in  1  core clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- imem_req  out  1  fetch request; high only in FETCH
- imem_ack  in  1  instruction valid this cycle; sampled only in FETCH
- instr  in  32  instruction word; captured into IR on the FETCH cycle with imem_ack=1
- rs1, rs2, rd  out  5 each  IR[19:15], IR[24:20], IR[11:7]
- alu_op  out  3  ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SLT=7
- alu_src_imm  out  1  1: ALU b = imm; 0: ALU b = rs2 data
- imm  out  32  sign-extended IR[31:20]; 0 for R-type
- rf_we  out  1  register write strobe; one cycle, in WRITEBACK only
- pc_we  out  1  PC <= PC+4 strobe; one cycle, in WRITEBACK only
- halted  out  1  sticky; illegal instruction seen
- instret  out  32  retired-instruction counter

## Operation
- States: IDLE -> FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH. Also HALT.
- IDLE: entered on reset; every output is 0. Moves to FETCH unconditionally on the next cycle.
- FETCH: imem_req=1. If imem_ack=1, IR <= instr and go to DECODE. Otherwise stay in FETCH; wait indefinitely.
- DECODE:
  - Legal instruction: go to EXECUTE.
  - Illegal instruction: go to HALT. No register write, no PC update, instret unchanged.
- Legal instructions:
  - Opcode 0110011 (R-type), funct7 = 0000000: funct3 000 ADD, 001 SLL, 010 SLT, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - Opcode 0110011 with funct7 = 0100000 and funct3 = 000: SUB.
  - Opcode 0010011 (I-type), alu_src_imm=1: funct3 000 ADDI, 010 SLTI, 100 XORI, 110 ORI, 111 ANDI.
  - Opcode 0010011: SLLI with imm[11:5] = 0; SRLI with imm[11:5] = 0.
- Illegal: everything else, including SLTU/SLTIU (funct3 011), SRA/SRAI, other funct7 values, and 0x00000000.
- EXECUTE: one cycle. alu_op, alu_src_imm and imm are stable so the combinational ALU result settles.
- WRITEBACK:
  - pc_we=1 and instret += 1.
  - rf_we=1 unless rd = 0; writes to x0 are suppressed.
  - Then go to FETCH.
- rs1, rs2, rd, alu_op, alu_src_imm and imm are decoded from IR. They are held constant from DECODE through WRITEBACK.
- HALT: absorbing. All strobes are 0 and halted=1. Only rst_n leaves HALT.
- instret wraps from 0xFFFFFFFF to 0.

## Timing
- All outputs are functions of registered state (state, IR, instret). There is no combinational path from imem_ack or instr to any output.
- Reset: rst_n sampled low at an edge gives state=IDLE, IR=0, instret=0 and halted=0 after that edge. All outputs read 0 during and after reset until FETCH.
- Reset in any state, including mid-WRITEBACK, aborts the instruction. No rf_we or pc_we is produced in the cycle after the reset edge.
- Latency with zero-wait memory (imem_ack high on the first FETCH cycle): 4 cycles per instruction, FETCH/DECODE/EXECUTE/WRITEBACK.
- Each wait cycle adds 1 cycle in FETCH.
- imem_ack=1 outside FETCH is ignored.
- First fetch request appears 1 cycle after rst_n rises (the IDLE cycle).

## Structure
- cpu_pkg holds:
  - alu_op_t, encoded in the order above and shared with alu;
  - opcode constants OP_REG = 7'b0110011 and OP_IMM = 7'b0010011;
  - funct7 constants;
  - ctrl_state_t {IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT}.
- Sub-module instr_decoder is purely combinational: IR in; legal, alu_op, alu_src_imm and imm out. It is reused by any later pipelined control.
- Top level holds the FSM, IR and instret.

## Test plan
- Reset, then imem_ack tied high, instr = 0x005303B3 (add x7,x6,x5):
  - imem_req in cycle 1;
  - in WRITEBACK: rf_we=1, rd=7, rs1=6, rs2=5, alu_op=0, alu_src_imm=0;
  - instret=1 after 4 cycles.
- instr = 0xFFF30393 (addi x7,x6,-1): alu_src_imm=1, imm=0xFFFFFFFF, alu_op=0.
- instr = 0x40530033 (sub x0,x6,x5): alu_op=1, rf_we=0 (rd=0), pc_we=1, instret increments.
- imem_ack held low for 3 cycles in FETCH: imem_req stays high, no state advance; instruction completes 3 cycles later than the zero-wait case.
- instr = 0x00000000: go to HALT after DECODE; halted=1; no rf_we or pc_we; instret unchanged; further imem_ack ignored; rst_n low for 1 cycle clears halted.
- rst_n pulled low during EXECUTE of a legal instruction: no rf_we or pc_we pulse; state=IDLE; instret unchanged.
- instret preloaded via force to 0xFFFFFFFF, one legal instruction: instret = 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared RV32I control types: ALU operation encoding, opcode/funct constants
// and the multi-cycle controller state encoding.
package cpu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_op_t;

    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } ctrl_state_t;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I ALU-instruction decoder: classifies IR as legal and
// derives the ALU operation, operand select and sign-extended immediate.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [31:0] ir,
    output logic        legal,
    output alu_op_t     alu_op,
    output logic        alu_src_imm,
    output logic [31:0] imm
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    always_comb begin
        legal       = 1'b0;
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        imm         = 32'd0;
        case (opcode)
            OP_REG: begin
                if (funct7 == F7_BASE) begin
                    legal = 1'b1;
                    case (funct3)
                        F3_ADD:  alu_op = ALU_ADD;
                        F3_SLL:  alu_op = ALU_SLL;
                        F3_SLT:  alu_op = ALU_SLT;
                        F3_XOR:  alu_op = ALU_XOR;
                        F3_SR:   alu_op = ALU_SRL;
                        F3_OR:   alu_op = ALU_OR;
                        F3_AND:  alu_op = ALU_AND;
                        default: legal  = 1'b0;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    legal  = 1'b1;
                    alu_op = ALU_SUB;
                end
            end
            OP_IMM: begin
                legal = 1'b1;
                case (funct3)
                    F3_ADD:  alu_op = ALU_ADD;
                    F3_SLT:  alu_op = ALU_SLT;
                    F3_XOR:  alu_op = ALU_XOR;
                    F3_OR:   alu_op = ALU_OR;
                    F3_AND:  alu_op = ALU_AND;
                    // Shift immediates are only legal with imm[11:5] clear (no SRAI).
                    F3_SLL: begin
                        alu_op = ALU_SLL;
                        legal  = (funct7 == F7_BASE);
                    end
                    F3_SR: begin
                        alu_op = ALU_SRL;
                        legal  = (funct7 == F7_BASE);
                    end
                    default: legal = 1'b0;
                endcase
                if (legal) begin
                    alu_src_imm = 1'b1;
                    imm         = sext12(ir[31:20]);
                end else begin
                    alu_op = ALU_ADD;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv32_multicycle_control.sv
// Multi-cycle RV32I control FSM: fetch handshake, decode of R/I ALU ops,
// register-file / PC strobes in writeback, retired-instruction counting.
module rv32_multicycle_control
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] instr,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [2:0]  alu_op,
    output logic        alu_src_imm,
    output logic [31:0] imm,
    output logic        rf_we,
    output logic        pc_we,
    output logic        halted,
    output logic [31:0] instret
);

    ctrl_state_t state;
    ctrl_state_t next_state;
    logic [31:0] ir;

    logic        dec_legal;
    alu_op_t     dec_op;
    logic        dec_src_imm;
    logic [31:0] dec_imm;

    instr_decoder u_decoder (
        .ir          (ir),
        .legal       (dec_legal),
        .alu_op      (dec_op),
        .alu_src_imm (dec_src_imm),
        .imm         (dec_imm)
    );

    // IR is zero out of reset, so every decoded field also reads zero in IDLE.
    assign rs1         = ir[19:15];
    assign rs2         = ir[24:20];
    assign rd          = ir[11:7];
    assign alu_op      = dec_op;
    assign alu_src_imm = dec_src_imm;
    assign imm         = dec_imm;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        imem_req   = 1'b0;
        rf_we      = 1'b0;
        pc_we      = 1'b0;
        halted     = 1'b0;
        case (state)
            IDLE:      next_state = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) next_state = DECODE;
            end
            DECODE:    next_state = dec_legal ? EXECUTE : HALT;
            EXECUTE:   next_state = WRITEBACK;
            WRITEBACK: begin
                pc_we      = 1'b1;
                rf_we      = (rd != 5'd0);
                next_state = FETCH;
            end
            HALT:      halted = 1'b1;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir <= 32'd0;
        end else if (state == FETCH && imem_ack) begin
            ir <= instr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instret <= 32'd0;
        end else if (state == WRITEBACK) begin
            instret <= instret + 32'd1;
        end
    end

endmodule

// File: tb/tb_rv32_multicycle_control.sv
// Self-checking bench for rv32_multicycle_control: directed cases plus random
// legal/illegal instructions assembled from a mnemonic table.
module tb_rv32_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        imem_req;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  alu_op;
    logic        alu_src_imm;
    logic [31:0] imm;
    logic        rf_we, pc_we, halted;
    logic [31:0] instret;

    int vectors = 0;
    int fails   = 0;
    logic [31:0] exp_instret = 32'd0;

    rv32_multicycle_control dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .instr       (instr),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .imm         (imm),
        .rf_we       (rf_we),
        .pc_we       (pc_we),
        .halted      (halted),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] word;
        logic        legal;
        logic [2:0]  op;
        logic        src;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } exp_t;

    // Mnemonic selectors for make_legal
    localparam int M_ADD = 0, M_SUB = 1, M_ADDI = 8;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Assemble one legal instruction from its mnemonic and record what the
    // ISA says the control outputs must be.
    function automatic exp_t make_legal(input int sel, input logic [4:0] d, input logic [4:0] s1,
                                        input logic [4:0] s2, input logic [11:0] imm12);
        exp_t e;
        logic is_imm, is_shift;
        logic [2:0] f3, op;
        logic [6:0] f7;
        logic [11:0] iv;
        is_imm = 1'b0; is_shift = 1'b0; f3 = 3'd0; op = 3'd0; f7 = 7'd0;
        case (sel)
            0:  begin f3 = 3'd0; op = 3'd0; end
            1:  begin f3 = 3'd0; op = 3'd1; f7 = 7'b0100000; end
            2:  begin f3 = 3'd1; op = 3'd5; end
            3:  begin f3 = 3'd2; op = 3'd7; end
            4:  begin f3 = 3'd4; op = 3'd4; end
            5:  begin f3 = 3'd5; op = 3'd6; end
            6:  begin f3 = 3'd6; op = 3'd3; end
            7:  begin f3 = 3'd7; op = 3'd2; end
            8:  begin f3 = 3'd0; op = 3'd0; is_imm = 1'b1; end
            9:  begin f3 = 3'd2; op = 3'd7; is_imm = 1'b1; end
            10: begin f3 = 3'd4; op = 3'd4; is_imm = 1'b1; end
            11: begin f3 = 3'd6; op = 3'd3; is_imm = 1'b1; end
            12: begin f3 = 3'd7; op = 3'd2; is_imm = 1'b1; end
            13: begin f3 = 3'd1; op = 3'd5; is_imm = 1'b1; is_shift = 1'b1; end
            default: begin f3 = 3'd5; op = 3'd6; is_imm = 1'b1; is_shift = 1'b1; end
        endcase
        e.legal = 1'b1;
        e.op    = op;
        e.rd    = d;
        e.rs1   = s1;
        if (!is_imm) begin
            e.word = {f7, s2, s1, f3, d, 7'b0110011};
            e.rs2  = s2;
            e.src  = 1'b0;
            e.imm  = 32'd0;
        end else begin
            iv     = is_shift ? {7'd0, imm12[4:0]} : imm12;
            e.word = {iv, s1, f3, d, 7'b0010011};
            e.rs2  = iv[4:0];
            e.src  = 1'b1;
            e.imm  = {{20{iv[11]}}, iv};
        end
        return e;
    endfunction

    function automatic exp_t make_illegal(input int sel, input logic [4:0] d, input logic [4:0] s1,
                                          input logic [4:0] s2, input logic [11:0] imm12);
        exp_t e;
        e = '0;
        case (sel)
            0: e.word = 32'd0;
            1: e.word = {7'd0, s2, s1, 3'b011, d, 7'b0110011};
            2: e.word = {7'b0100000, s2, s1, 3'b101, d, 7'b0110011};
            3: e.word = {imm12, s1, 3'b011, d, 7'b0010011};
            4: e.word = {7'b0100000, s2, s1, 3'b101, d, 7'b0010011};
            5: e.word = {7'b0000001, s2, s1, 3'b000, d, 7'b0110011};
            6: e.word = {7'b0100000, s2, s1, 3'b100, d, 7'b0110011};
            7: e.word = {imm12, s1, 3'b000, d, 7'b0110111};
            default: e.word = {7'b0000001, s2, s1, 3'b001, d, 7'b0010011};
        endcase
        return e;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        imem_ack = 1'($urandom);
        instr = $urandom;
        step();
        chk("rst_strobes", 32'({imem_req, rf_we, pc_we, halted}), 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_fields", 32'({rs1, rs2, rd, alu_op, alu_src_imm}), 32'd0);
        chk("rst_imm", imm, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_req", 32'(imem_req), 32'd0);
        step();
        exp_instret = 32'd0;
        chk("first_req", 32'(imem_req), 32'd1);
    endtask

    // Entered with the controller in FETCH; leaves it in FETCH (legal) or HALT.
    task automatic run_instr(input exp_t e, input int waits);
        instr = e.word;
        for (int i = 0; i < waits; i++) begin
            imem_ack = 1'b0;
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_strobes", 32'({rf_we, pc_we}), 32'd0);
            step();
        end
        imem_ack = 1'b1;
        chk("fetch_req", 32'(imem_req), 32'd1);
        step();
        // DECODE: bus noise must not be captured
        imem_ack = 1'($urandom);
        instr = $urandom;
        chk("dec_req", 32'(imem_req), 32'd0);
        chk("dec_strobes", 32'({rf_we, pc_we}), 32'd0);
        if (e.legal) begin
            chk("dec_regs", 32'({rs1, rs2, rd}), 32'({e.rs1, e.rs2, e.rd}));
            chk("dec_op", 32'({alu_op, alu_src_imm}), 32'({e.op, e.src}));
            chk("dec_imm", imm, e.imm);
            step();
            chk("ex_strobes", 32'({imem_req, rf_we, pc_we, halted}), 32'd0);
            chk("ex_op", 32'({alu_op, alu_src_imm}), 32'({e.op, e.src}));
            chk("ex_instret", instret, exp_instret);
            step();
            chk("wb_pc_we", 32'(pc_we), 32'd1);
            chk("wb_rf_we", 32'(rf_we), 32'(e.rd != 5'd0));
            chk("wb_regs", 32'({rs1, rs2, rd}), 32'({e.rs1, e.rs2, e.rd}));
            chk("wb_op", 32'({alu_op, alu_src_imm}), 32'({e.op, e.src}));
            chk("wb_imm", imm, e.imm);
            chk("wb_misc", 32'({imem_req, halted}), 32'd0);
            step();
            exp_instret = exp_instret + 32'd1;
            chk("retire_instret", instret, exp_instret);
            chk("next_req", 32'(imem_req), 32'd1);
            chk("next_strobes", 32'({rf_we, pc_we}), 32'd0);
        end else begin
            step();
            for (int i = 0; i < 3; i++) begin
                chk("halt_flag", 32'(halted), 32'd1);
                chk("halt_strobes", 32'({imem_req, rf_we, pc_we}), 32'd0);
                chk("halt_instret", instret, exp_instret);
                imem_ack = 1'b1;
                instr = 32'h005303B3;
                step();
            end
        end
    endtask

    task automatic abort_at(input int phase);
        exp_t e;
        e = make_legal(M_ADD, 5'd9, 5'd3, 5'd4, 12'd0);
        instr = e.word;
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        for (int i = 0; i < phase; i++) step();
        rst_n = 1'b0;
        step();
        chk("abort_strobes", 32'({imem_req, rf_we, pc_we, halted}), 32'd0);
        chk("abort_instret", instret, 32'd0);
        step();
        chk("abort_hold", 32'({imem_req, rf_we, pc_we}), 32'd0);
        rst_n = 1'b1;
        step();
        exp_instret = 32'd0;
        chk("abort_refetch", 32'(imem_req), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        do_reset();

        // add x7,x6,x5 / addi x7,x6,-1 / sub x0,x6,x5 with zero wait states
        e = make_legal(M_ADD, 5'd7, 5'd6, 5'd5, 12'd0);
        run_instr(e, 0);
        e = make_legal(M_ADDI, 5'd7, 5'd6, 5'd0, 12'hFFF);
        run_instr(e, 0);
        e = make_legal(M_SUB, 5'd0, 5'd6, 5'd5, 12'd0);
        run_instr(e, 0);
        // three memory wait cycles
        e = make_legal(M_ADD, 5'd7, 5'd6, 5'd5, 12'd0);
        run_instr(e, 3);

        for (int n = 0; n < 40; n++) begin
            logic [4:0] d;
            d = (($urandom % 4) == 0) ? 5'd0 : 5'($urandom);
            e = make_legal(int'($urandom_range(0, 14)), d, 5'($urandom), 5'($urandom),
                           12'($urandom));
            run_instr(e, int'($urandom_range(0, 3)));
        end

        // illegal all-zero word halts; reset releases it
        e = make_illegal(0, 5'd0, 5'd0, 5'd0, 12'd0);
        run_instr(e, 0);
        do_reset();

        for (int n = 1; n <= 8; n++) begin
            e = make_legal(int'($urandom_range(0, 14)), 5'd1, 5'd2, 5'd3, 12'($urandom));
            run_instr(e, 0);
            e = make_illegal(n, 5'($urandom), 5'($urandom), 5'($urandom), 12'($urandom));
            run_instr(e, int'($urandom_range(0, 2)));
            do_reset();
        end

        abort_at(1);
        abort_at(2);

        // instret wraps to zero
        force dut.instret = 32'hFFFF_FFFF;
        #1;
        release dut.instret;
        exp_instret = 32'hFFFF_FFFF;
        chk("preload", instret, exp_instret);
        e = make_legal(M_ADDI, 5'd1, 5'd1, 5'd0, 12'd1);
        run_instr(e, 0);
        chk("wrap_zero", instret, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
